// File: rtl/mem_bus_ctrl.sv
// Bus controller between the picoRV native memory port and its slaves.
// Routes SRAM-window accesses to a registered SRAM (one-cycle select pulse,
// wait for its ready with a timeout) and answers the GPIO and cycle-counter
// registers locally. Unmapped and timed-out accesses set a sticky error flag.
module mem_bus_ctrl #(
  parameter int unsigned SRAM_ADDRWIDTH = 13,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_wstrb,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,
  output logic                      sram_select,
  output logic [3:0]                sram_wstrb,
  output logic [SRAM_ADDRWIDTH-1:0] sram_addr,
  output logic [31:0]               sram_wdata,
  input  logic                      sram_ready,
  input  logic [31:0]               sram_rdata,
  output logic [7:0]                gpio_out,
  output logic                      bus_error
);

  localparam logic [31:0] GpioAddr   = 32'h8000_0000;
  localparam logic [31:0] CyclesAddr = 32'h8000_0004;
  localparam logic [7:0]  TmoLimit   = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StSramWait,
    StResp
  } state_e;

  state_e                    state_q, state_d;
  logic                      mem_ready_q, mem_ready_d;
  logic [31:0]               mem_rdata_q, mem_rdata_d;
  logic                      sram_select_q, sram_select_d;
  logic [3:0]                sram_wstrb_q, sram_wstrb_d;
  logic [SRAM_ADDRWIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]               sram_wdata_q, sram_wdata_d;
  logic [7:0]                gpio_q, gpio_d;
  logic                      bus_error_q, bus_error_d;
  logic [31:0]               cycles_q, cycles_d;
  logic [7:0]                tmo_q, tmo_d;

  logic sram_hit, gpio_hit, cycles_hit;

  // Address decode of the current CPU request.
  always_comb begin
    sram_hit   = (mem_addr[31:SRAM_ADDRWIDTH] == '0);
    gpio_hit   = (mem_addr == GpioAddr);
    cycles_hit = (mem_addr == CyclesAddr);
  end

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d       = state_q;
    mem_ready_d   = 1'b0;
    mem_rdata_d   = mem_rdata_q;
    sram_select_d = 1'b0;
    sram_wstrb_d  = sram_wstrb_q;
    sram_addr_d   = sram_addr_q;
    sram_wdata_d  = sram_wdata_q;
    gpio_d        = gpio_q;
    bus_error_d   = bus_error_q;
    cycles_d      = cycles_q + 32'd1;
    tmo_d         = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          if (sram_hit) begin
            sram_select_d = 1'b1;
            sram_addr_d   = mem_addr[SRAM_ADDRWIDTH-1:0];
            sram_wstrb_d  = mem_wstrb;
            sram_wdata_d  = mem_wdata;
            tmo_d         = 8'd0;
            state_d       = StSramWait;
          end else begin
            mem_ready_d = 1'b1;
            state_d     = StResp;
            if (gpio_hit) begin
              mem_rdata_d = {24'b0, gpio_q};
              if (mem_wstrb[0]) gpio_d = mem_wdata[7:0];
            end else if (cycles_hit) begin
              // Counter value as seen on the edge that raises mem_ready.
              mem_rdata_d = cycles_q;
            end else begin
              mem_rdata_d = 32'd0;
              bus_error_d = 1'b1;
            end
          end
        end
      end
      StSramWait: begin
        if (sram_ready) begin
          mem_rdata_d = sram_rdata;
          mem_ready_d = 1'b1;
          state_d     = StResp;
        end else if (tmo_q == TmoLimit) begin
          mem_rdata_d = 32'd0;
          mem_ready_d = 1'b1;
          bus_error_d = 1'b1;
          state_d     = StResp;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StResp: begin
        // CPU still holds mem_valid this cycle; never accept it here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= 32'd0;
      sram_select_q <= 1'b0;
      sram_wstrb_q  <= 4'd0;
      sram_addr_q   <= '0;
      sram_wdata_q  <= 32'd0;
      gpio_q        <= 8'd0;
      bus_error_q   <= 1'b0;
      cycles_q      <= 32'd0;
      tmo_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      sram_select_q <= sram_select_d;
      sram_wstrb_q  <= sram_wstrb_d;
      sram_addr_q   <= sram_addr_d;
      sram_wdata_q  <= sram_wdata_d;
      gpio_q        <= gpio_d;
      bus_error_q   <= bus_error_d;
      cycles_q      <= cycles_d;
      tmo_q         <= tmo_d;
    end
  end

  // Registered values drive the ports directly.
  always_comb begin
    mem_ready   = mem_ready_q;
    mem_rdata   = mem_rdata_q;
    sram_select = sram_select_q;
    sram_wstrb  = sram_wstrb_q;
    sram_addr   = sram_addr_q;
    sram_wdata  = sram_wdata_q;
    gpio_out    = gpio_q;
    bus_error   = bus_error_q;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a small registered SRAM model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sram_select;
  logic [3:0]  sram_wstrb;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ready;
  logic [31:0] sram_rdata;
  logic [7:0]  gpio_out;
  logic        bus_error;

  logic        sram_en;
  logic        stray;
  logic        sram_ready_q;
  logic [31:0] mem_arr [0:2047];

  int vectors = 0;
  int fails   = 0;

  mem_bus_ctrl #(
    .SRAM_ADDRWIDTH(13),
    .TIMEOUT       (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .sram_select(sram_select),
    .sram_wstrb (sram_wstrb),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ready (sram_ready),
    .sram_rdata (sram_rdata),
    .gpio_out   (gpio_out),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  // SRAM model: answers one cycle after select (when enabled).
  always @(posedge clk) begin
    sram_ready_q <= sram_select & sram_en;
    if (sram_select) begin
      sram_rdata <= mem_arr[sram_addr[12:2]];
      for (int b = 0; b < 4; b++) begin
        if (sram_wstrb[b]) mem_arr[sram_addr[12:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  assign sram_ready = sram_ready_q | stray;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU transaction, starting and ending on a falling edge.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rdata, output int lat, output int sels,
                        output logic [31:0] sel_addr, output logic [31:0] sel_wdata);
    bit done;
    done      = 1'b0;
    lat       = 0;
    sels      = 0;
    rdata     = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (sram_select) begin
        sels++;
        sel_addr  = 32'(sram_addr);
        sel_wdata = sram_wdata;
      end
      if (mem_ready) begin
        done  = 1'b1;
        rdata = mem_rdata;
      end
    end
    if (!done) check("ready_within_bound", 32'd0, 32'd1);
    // CPU keeps valid through the ready cycle; controller must not re-accept.
    @(negedge clk);
    if (sram_select) sels++;
    check("ready_single_pulse", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
  endtask

  logic [31:0] rd, sa, sw, c1, c2;
  int          lat, sels;

  initial begin
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    sram_en   = 1'b1;
    stray     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_sram_select", 32'(sram_select), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_gpio", 32'(gpio_out), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // SRAM write then read
    access(32'h0000_0010, 32'hA5A5_1234, 4'b1111, rd, lat, sels, sa, sw);
    check("sram_wr_latency", 32'(lat), 32'd3);
    check("sram_wr_selects", 32'(sels), 32'd1);
    check("sram_wr_addr", sa, 32'h0000_0010);
    check("sram_wr_data", sw, 32'hA5A5_1234);
    check("sram_wr_strb", 32'(sram_wstrb), 32'hF);
    access(32'h0000_0010, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("sram_rd_latency", 32'(lat), 32'd3);
    check("sram_rd_selects", 32'(sels), 32'd1);
    check("sram_rd_data", rd, 32'hA5A5_1234);
    check("sram_hold_addr", 32'(sram_addr), 32'h0000_0010);

    // GPIO byte strobes
    access(32'h8000_0000, 32'h0000_00C3, 4'b0001, rd, lat, sels, sa, sw);
    check("gpio_wr_latency", 32'(lat), 32'd1);
    check("gpio_wr_value", 32'(gpio_out), 32'hC3);
    access(32'h8000_0000, 32'h0000_0011, 4'b0010, rd, lat, sels, sa, sw);
    check("gpio_wr_b1_ignored", 32'(gpio_out), 32'hC3);
    access(32'h8000_0000, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("gpio_rd_latency", 32'(lat), 32'd1);
    check("gpio_rd_data", rd, 32'h0000_00C3);
    check("gpio_no_select", 32'(sels), 32'd0);

    // Cycle counter: reads issued 10 cycles apart
    access(32'h8000_0004, 32'h0, 4'b0000, c1, lat, sels, sa, sw);
    repeat (8) @(negedge clk);
    access(32'h8000_0004, 32'h0, 4'b0000, c2, lat, sels, sa, sw);
    check("cycles_delta", c2 - c1, 32'd10);
    access(32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, rd, lat, sels, sa, sw);
    check("cycles_wr_latency", 32'(lat), 32'd1);
    check("cycles_wr_no_error", 32'(bus_error), 32'd0);
    check("cycles_wr_gpio_kept", 32'(gpio_out), 32'hC3);

    // Unmapped access
    access(32'h4000_0000, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("unmapped_latency", 32'(lat), 32'd1);
    check("unmapped_rdata", rd, 32'd0);
    check("unmapped_error", 32'(bus_error), 32'd1);
    check("unmapped_no_select", 32'(sels), 32'd0);
    access(32'h8000_0000, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("error_sticky_gpio", 32'(bus_error), 32'd1);
    check("gpio_rd_after_err", rd, 32'h0000_00C3);
    access(32'h0000_0010, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("error_sticky_sram", 32'(bus_error), 32'd1);

    // Timeout with a silent SRAM
    reset = 1'b1;
    @(negedge clk);
    check("reset_clears_error", 32'(bus_error), 32'd0);
    reset   = 1'b0;
    sram_en = 1'b0;
    @(negedge clk);
    access(32'h0000_0020, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("timeout_latency", 32'(lat), 32'd17);
    check("timeout_rdata", rd, 32'd0);
    check("timeout_error", 32'(bus_error), 32'd1);
    check("timeout_selects", 32'(sels), 32'd1);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check("stray_no_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    check("stray_no_ready_2", 32'(mem_ready), 32'd0);
    sram_en = 1'b1;

    // Reset in the select cycle
    mem_addr  = 32'h0000_0010;
    mem_wstrb = 4'b0000;
    mem_valid = 1'b1;
    @(negedge clk);
    check("pre_reset_select", 32'(sram_select), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_select", 32'(sram_select), 32'd0);
    check("midrst_ready", 32'(mem_ready), 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    check("midrst_addr", 32'(sram_addr), 32'd0);
    check("midrst_gpio", 32'(gpio_out), 32'd0);
    check("midrst_error", 32'(bus_error), 32'd0);
    mem_valid = 1'b0;
    stray     = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_idle", 32'(mem_ready), 32'd0);
    access(32'h0000_0010, 32'h0, 4'b0000, rd, lat, sels, sa, sw);
    check("postrst_latency", 32'(lat), 32'd3);
    check("postrst_rdata", rd, 32'hA5A5_1234);
    check("postrst_selects", 32'(sels), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
